// File: rtl/fpu_pkg.sv
// Types and helpers shared by the FPU datapath blocks.
// Covers rounding modes, exception flag positions and operand classes.
package fpu_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_e;

  localparam int FLG_W  = 5;
  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_class_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise/round stage for a raw significand product.
// Applies overflow saturation and flush-to-zero on the final exponent.
module fp_round_norm
  import fpu_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                     sign_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [1:0]               rnd_i,
  output logic [EXP_W+MAN_W:0]     res_o,
  output logic [FLG_W-1:0]         flags_o
);
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic [PW-1:0]        p_norm;
  logic signed [EW-1:0] exp_norm;
  logic signed [EW-1:0] exp_fin;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       frac_r;
  logic                 guard, sticky, inc, inexact, to_inf;

  always_comb begin
    // Leading one is forced to the top bit before the fraction is sliced.
    p_norm   = prod_i[PW-1] ? prod_i : (prod_i << 1);
    exp_norm = exp_i + {{(EW-1){1'b0}}, prod_i[PW-1]};
    frac_t   = p_norm[PW-2 -: MAN_W];
    guard    = p_norm[PW-2-MAN_W];
    sticky   = |p_norm[PW-3-MAN_W:0];
    inexact  = guard | sticky;

    inc = 1'b0;
    case (rnd_mode_e'(rnd_i))
      RND_RNE: inc = guard & (sticky | frac_t[0]);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = inexact & ~sign_i;
      RND_RDN: inc = inexact & sign_i;
      default: inc = 1'b0;
    endcase

    frac_r  = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    exp_fin = exp_norm + {{(EW-1){1'b0}}, frac_r[MAN_W]};

    to_inf = (rnd_mode_e'(rnd_i) == RND_RNE) |
             ((rnd_mode_e'(rnd_i) == RND_RUP) & ~sign_i) |
             ((rnd_mode_e'(rnd_i) == RND_RDN) & sign_i);

    res_o            = {sign_i, exp_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_o          = '0;
    flags_o[FLG_NX]  = inexact;

    if (exp_fin >= EXP_MAX) begin
      res_o           = to_inf ? {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                               : {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flags_o[FLG_OF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      res_o           = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o[FLG_UF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with valid/ready flow control and tag passthrough.
// Specials resolve in stage 2; the rounder runs combinationally ahead of the output register.
module fp_mul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  input  logic [1:0]             rnd_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [4:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic fp_class_t classify(input logic [W-2:0] mag);
    fp_class_t c;
    logic      exp_ones, exp_zero, frac_zero;
    exp_ones  = &mag[W-2 -: EXP_W];
    exp_zero  = ~|mag[W-2 -: EXP_W];
    frac_zero = ~|mag[MAN_W-1:0];
    c.is_zero = exp_zero;
    c.is_inf  = exp_ones & frac_zero;
    c.is_nan  = exp_ones & ~frac_zero;
    c.is_snan = exp_ones & ~frac_zero & ~mag[MAN_W-1];
    return c;
  endfunction

  logic stall, adv;

  logic                 vld_p1_d, vld_p1_q;
  logic                 sign_p1_d, sign_p1_q;
  logic [EXP_W-1:0]     exp_a_p1_d, exp_a_p1_q, exp_b_p1_d, exp_b_p1_q;
  logic [MAN_W-1:0]     frac_a_p1_d, frac_a_p1_q, frac_b_p1_d, frac_b_p1_q;
  fp_class_t            cls_a_p1_d, cls_a_p1_q, cls_b_p1_d, cls_b_p1_q;
  logic [1:0]           rnd_p1_d, rnd_p1_q;
  logic [TAG_W-1:0]     tag_p1_d, tag_p1_q;

  logic                 vld_p2_d, vld_p2_q;
  logic                 sign_p2_d, sign_p2_q;
  logic [PW-1:0]        prod_p2_d, prod_p2_q;
  logic signed [EW-1:0] exp_p2_d, exp_p2_q;
  logic [1:0]           rnd_p2_d, rnd_p2_q;
  logic [TAG_W-1:0]     tag_p2_d, tag_p2_q;
  logic                 spec_p2_d, spec_p2_q;
  logic [W-1:0]         spec_res_p2_d, spec_res_p2_q;
  logic [4:0]           spec_flg_p2_d, spec_flg_p2_q;

  logic                 out_valid_d, out_valid_q;
  logic [W-1:0]         result_d, result_q;
  logic [TAG_W-1:0]     out_tag_d, out_tag_q;
  logic [4:0]           flags_d, flags_q;

  logic                 nan_in, inf_zero;
  logic [W-1:0]         rn_res;
  logic [4:0]           rn_flg;

  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Stage 1: decode and classify operands
  always_comb begin
    vld_p1_d    = adv ? in_valid : vld_p1_q;
    sign_p1_d   = sign_p1_q;
    exp_a_p1_d  = exp_a_p1_q;
    exp_b_p1_d  = exp_b_p1_q;
    frac_a_p1_d = frac_a_p1_q;
    frac_b_p1_d = frac_b_p1_q;
    cls_a_p1_d  = cls_a_p1_q;
    cls_b_p1_d  = cls_b_p1_q;
    rnd_p1_d    = rnd_p1_q;
    tag_p1_d    = tag_p1_q;
    if (adv && in_valid) begin
      sign_p1_d   = a_operand[W-1] ^ b_operand[W-1];
      exp_a_p1_d  = a_operand[W-2 -: EXP_W];
      exp_b_p1_d  = b_operand[W-2 -: EXP_W];
      frac_a_p1_d = a_operand[MAN_W-1:0];
      frac_b_p1_d = b_operand[MAN_W-1:0];
      cls_a_p1_d  = classify(a_operand[W-2:0]);
      cls_b_p1_d  = classify(b_operand[W-2:0]);
      rnd_p1_d    = rnd_mode;
      tag_p1_d    = in_tag;
    end
  end

  // Stage 2: significand product, biased exponent sum, special-case result
  assign nan_in   = cls_a_p1_q.is_nan | cls_b_p1_q.is_nan;
  assign inf_zero = (cls_a_p1_q.is_inf & cls_b_p1_q.is_zero) |
                    (cls_a_p1_q.is_zero & cls_b_p1_q.is_inf);

  always_comb begin
    vld_p2_d      = adv ? vld_p1_q : vld_p2_q;
    sign_p2_d     = sign_p2_q;
    prod_p2_d     = prod_p2_q;
    exp_p2_d      = exp_p2_q;
    rnd_p2_d      = rnd_p2_q;
    tag_p2_d      = tag_p2_q;
    spec_p2_d     = spec_p2_q;
    spec_res_p2_d = spec_res_p2_q;
    spec_flg_p2_d = spec_flg_p2_q;
    if (adv && vld_p1_q) begin
      sign_p2_d     = sign_p1_q;
      prod_p2_d     = PW'({1'b1, frac_a_p1_q}) * PW'({1'b1, frac_b_p1_q});
      exp_p2_d      = $signed({2'b00, exp_a_p1_q}) + $signed({2'b00, exp_b_p1_q}) - BIAS;
      rnd_p2_d      = rnd_p1_q;
      tag_p2_d      = tag_p1_q;
      spec_p2_d     = 1'b0;
      spec_res_p2_d = '0;
      spec_flg_p2_d = '0;
      if (nan_in || inf_zero) begin
        spec_p2_d             = 1'b1;
        spec_res_p2_d         = QNAN;
        spec_flg_p2_d[FLG_NV] = inf_zero | cls_a_p1_q.is_snan | cls_b_p1_q.is_snan;
      end else if (cls_a_p1_q.is_inf || cls_b_p1_q.is_inf) begin
        spec_p2_d     = 1'b1;
        spec_res_p2_d = {sign_p1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cls_a_p1_q.is_zero || cls_b_p1_q.is_zero) begin
        spec_p2_d     = 1'b1;
        spec_res_p2_d = {sign_p1_q, {(W-1){1'b0}}};
      end
    end
  end

  // Stage 3: normalise, round, select special or arithmetic result
  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .sign_i  (sign_p2_q),
    .prod_i  (prod_p2_q),
    .exp_i   (exp_p2_q),
    .rnd_i   (rnd_p2_q),
    .res_o   (rn_res),
    .flags_o (rn_flg)
  );

  always_comb begin
    out_valid_d = adv ? vld_p2_q : out_valid_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    flags_d     = flags_q;
    if (adv && vld_p2_q) begin
      result_d  = spec_p2_q ? spec_res_p2_q : rn_res;
      flags_d   = spec_p2_q ? spec_flg_p2_q : rn_flg;
      out_tag_d = tag_p2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      flags_q     <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q     <= sign_p1_d;
    exp_a_p1_q    <= exp_a_p1_d;
    exp_b_p1_q    <= exp_b_p1_d;
    frac_a_p1_q   <= frac_a_p1_d;
    frac_b_p1_q   <= frac_b_p1_d;
    cls_a_p1_q    <= cls_a_p1_d;
    cls_b_p1_q    <= cls_b_p1_d;
    rnd_p1_q      <= rnd_p1_d;
    tag_p1_q      <= tag_p1_d;
    sign_p2_q     <= sign_p2_d;
    prod_p2_q     <= prod_p2_d;
    exp_p2_q      <= exp_p2_d;
    rnd_p2_q      <= rnd_p2_d;
    tag_p2_q      <= tag_p2_d;
    spec_p2_q     <= spec_p2_d;
    spec_res_p2_q <= spec_res_p2_d;
    spec_flg_p2_q <= spec_flg_p2_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed IEEE cases, stall/reset scenarios and random traffic
// scored against an integer-arithmetic binary64 multiply model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a_op, b_op, result;
  logic [1:0]  rnd;
  logic [3:0]  tag_in, out_tag;
  logic [4:0]  flags;

  logic        v32, in_ready32, out_valid32;
  logic [31:0] a32, b32, result32;
  logic [1:0]  rnd32;
  logic [3:0]  tag32, out_tag32;
  logic [4:0]  flags32;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  tag_ctr  = 4'h0;
  logic        stim_done;
  logic        saw_stall, seen_vld;
  logic [63:0] stall_res;
  logic [3:0]  stall_tag;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_op), .b_operand(b_op), .rnd_mode(rnd), .in_tag(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(in_ready32),
    .a_operand(a32), .b_operand(b32), .rnd_mode(rnd32), .in_tag(tag32),
    .out_valid(out_valid32), .out_ready(1'b1), .result(result32),
    .out_tag(out_tag32), .flags(flags32)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, want);
    end
  endtask

  // Exact product as a wide integer, rounded by comparing the discarded remainder to half an ulp.
  function automatic logic [68:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] rm);
    logic        s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, inc, to_inf;
    int          ea, eb, e, sh;
    logic [51:0] fa, fb;
    logic [127:0] p, q, rem, half;
    logic [63:0] res;
    logic [4:0]  flg;
    s  = a[63] ^ b[63];
    ea = int'(a[62:52]); eb = int'(b[62:52]);
    fa = a[51:0];        fb = b[51:0];
    nan_a  = (ea == 2047) && (fa != 0);  nan_b  = (eb == 2047) && (fb != 0);
    snan_a = nan_a && !fa[51];           snan_b = nan_b && !fb[51];
    inf_a  = (ea == 2047) && (fa == 0);  inf_b  = (eb == 2047) && (fb == 0);
    zero_a = (ea == 0);                  zero_b = (eb == 0);
    flg = 5'b0;
    res = 64'h0;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      res    = 64'h7FF8000000000000;
      flg[4] = (inf_a && zero_b) || (zero_a && inf_b) || snan_a || snan_b;
    end else if (inf_a || inf_b) begin
      res = {s, 11'h7FF, 52'h0};
    end else if (zero_a || zero_b) begin
      res = {s, 63'h0};
    end else begin
      p = 128'({1'b1, fa}) * 128'({1'b1, fb});
      e = ea + eb - 1023;
      if (p[105]) begin sh = 53; e++; end else sh = 52;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 128'(1) << (sh - 1);
      case (rm)
        2'd0:    inc = (rem > half) || ((rem == half) && q[0]);
        2'd1:    inc = 1'b0;
        2'd2:    inc = (rem != 0) && !s;
        default: inc = (rem != 0) && s;
      endcase
      q = q + 128'(inc);
      if (q[53]) begin q = q >> 1; e++; end
      to_inf = (rm == 2'd0) || ((rm == 2'd2) && !s) || ((rm == 2'd3) && s);
      if (e >= 2047) begin
        res = to_inf ? {s, 11'h7FF, 52'h0} : {s, 11'h7FE, {52{1'b1}}};
        flg = 5'b00101;
      end else if (e <= 0) begin
        res = {s, 63'h0};
        flg = 5'b00011;
      end else begin
        res    = {s, e[10:0], q[51:0]};
        flg[0] = (rem != 0);
      end
    end
    return {flg, res};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [10:0] e;
    logic [51:0] f;
    int          cat;
    cat = int'($urandom_range(0, 15));
    f   = 52'({$urandom(), $urandom()});
    case (cat)
      0:       begin e = 11'h0; if ($urandom_range(0, 1) == 0) f = 52'h0; end
      1:       begin e = 11'h7FF; f = 52'h0; end
      2:       begin e = 11'h7FF; if (f == 52'h0) f = 52'h1; end
      3:       e = 11'($urandom_range(1900, 2046));
      4:       e = 11'($urandom_range(1, 120));
      5:       begin e = 11'($urandom_range(1000, 1050)); f = ($urandom_range(0, 1) == 0) ? 52'h0 : {52{1'b1}}; end
      default: e = 11'($urandom_range(900, 1150));
    endcase
    return {1'($urandom()), e, f};
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_res", result, e.res);
        check("sb_flg", 64'(flags), 64'(e.flg));
        check("sb_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm,
                      input logic [3:0] tg);
    exp_t e;
    int   tries;
    a_op = a; b_op = b; rnd = rm; tag_in = tg; in_valid = 1'b1;
    tries = 0;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      {e.flg, e.res} = ref_mul(a, b, rm);
      e.tag = tg;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] rm, input logic [63:0] want_res, input logic [4:0] want_flg);
    int lat;
    send(a, b, rm, tag_ctr);
    tag_ctr++;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, "_lat"}, 64'(lat), 64'd3);
    check({name, "_res"}, result, want_res);
    check({name, "_flg"}, 64'(flags), 64'(want_flg));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, limit %0d", $time, 500000);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_op = '0; b_op = '0; rnd = 2'd0; tag_in = '0;
    v32 = 1'b0; a32 = '0; b32 = '0; rnd32 = 2'd0; tag32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    result, 64'd0);
    check("rst_out_tag",   64'(out_tag), 64'd0);
    check("rst_flags",     64'(flags), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("mul_1p5x2",  64'h3FF8000000000000, 64'h4000000000000000, 2'd0, 64'h4008000000000000, 5'b00000);
    run_one("sq_rne",     64'h3FF0000000000001, 64'h3FF0000000000001, 2'd0, 64'h3FF0000000000002, 5'b00001);
    run_one("sq_rup",     64'h3FF0000000000001, 64'h3FF0000000000001, 2'd2, 64'h3FF0000000000003, 5'b00001);
    run_one("ovf_rne",    64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd0, 64'h7FF0000000000000, 5'b00101);
    run_one("ovf_rtz",    64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd1, 64'h7FEFFFFFFFFFFFFF, 5'b00101);
    run_one("ovf_neg_rdn",64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd3, 64'hFFF0000000000000, 5'b00101);
    run_one("ovf_neg_rup",64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd2, 64'hFFEFFFFFFFFFFFFF, 5'b00101);
    run_one("inf_x_zero", 64'h7FF0000000000000, 64'h0000000000000000, 2'd0, 64'h7FF8000000000000, 5'b10000);
    run_one("uflow",      64'h0010000000000000, 64'h3CB0000000000000, 2'd0, 64'h0000000000000000, 5'b00011);
    run_one("snan_in",    64'h7FF0000000000001, 64'h3FF0000000000000, 2'd0, 64'h7FF8000000000000, 5'b10000);
    run_one("qnan_in",    64'h7FF8000000000000, 64'h3FF0000000000000, 2'd0, 64'h7FF8000000000000, 5'b00000);
    run_one("ninf_x_2",   64'hFFF0000000000000, 64'h4000000000000000, 2'd0, 64'hFFF0000000000000, 5'b00000);
    run_one("daz_sub",    64'h000FFFFFFFFFFFFF, 64'hC000000000000000, 2'd0, 64'h8000000000000000, 5'b00000);

    a32 = 32'h3FC00000; b32 = 32'h40000000; rnd32 = 2'd0; tag32 = 4'h9; v32 = 1'b1;
    @(negedge clk);
    check("b32_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1 v32 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid32 && lat < 10);
    check("b32_lat", 64'(lat), 64'd3);
    check("b32_res", 64'(result32), 64'h40400000);
    check("b32_flg", 64'(flags32), 64'd0);
    check("b32_tag", 64'(out_tag32), 64'h9);
    @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 2'($urandom()), 4'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        saw_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) begin
            stall_res = result;
            stall_tag = out_tag;
          end
          if (!in_ready) saw_stall = 1'b1;
          @(posedge clk);
        end
        #1;
        check("stall_hold_res", result, stall_res);
        check("stall_hold_tag", 64'(out_tag), 64'(stall_tag));
        check("stall_in_ready_low", 64'(saw_stall), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 5) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op(), 2'($urandom()), tag_ctr);
          tag_ctr++;
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    for (int i = 0; i < 3; i++) begin
      send(64'h4000000000000000, 64'h4008000000000000, 2'd0, tag_ctr);
      tag_ctr++;
    end
    reset_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_result", result, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen_vld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen_vld = 1'b1;
    end
    check("post_rst_quiet", 64'(seen_vld), 64'd0);
    @(posedge clk);
    #1;
    run_one("post_rst", 64'h3FF8000000000000, 64'h4000000000000000, 2'd0, 64'h4008000000000000, 5'b00000);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
